// File: rtl/sd_pattern_detector.sv
// Programmable serial sequence detector: matches a runtime-loaded 1..MAX_LEN bit
// pattern on a qualified serial stream, with overlap control and a saturating match counter.
module sd_pattern_detector #(
    parameter int                  MAX_LEN     = 8,
    parameter int                  CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = 8'b0000_0110,
    parameter int                  DEF_LEN     = 4,
    parameter bit                  DEF_OVERLAP = 1'b1,
    localparam int                 LEN_W       = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               dout,
    output logic [3:0]         led,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] hist, pat, shifted, mask;
    logic [LEN_W-1:0]   len, fill, len_clamped, fill_next;
    logic               ovl, accept, hit;
    logic [3:0]         pat4;

    always_comb begin
        shifted = {hist[MAX_LEN-2:0], din};
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (LEN_W'(i) < len);
        accept = din_valid && !cfg_we;
        // Bits above len are don't-care, so only the masked window is compared.
        hit = accept && (len != '0) && (fill >= len - LEN_W'(1)) &&
              (((shifted ^ pat) & mask) == '0);
        len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        fill_next   = (fill >= len) ? len : fill + LEN_W'(1);
        pat4 = '0;
        for (int i = 0; i < 4 && i < MAX_LEN; i++)
            pat4[i] = pat[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat  <= DEF_PATTERN;
            len  <= LEN_W'(DEF_LEN);
            ovl  <= DEF_OVERLAP;
            hist <= '0;
            fill <= '0;
        end else if (cfg_we) begin
            pat  <= cfg_pattern;
            len  <= len_clamped;
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
        end else if (accept) begin
            hist <= shifted;
            if (hit)
                fill <= ovl ? fill : '0;
            else
                fill <= fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout        <= 1'b0;
            led         <= '0;
            match_count <= '0;
        end else begin
            dout <= hit;
            led  <= hit ? pat4 : 4'b0;
            // A clear that coincides with a match still counts that match.
            if (hit) begin
                if (clr_count)
                    match_count <= CNT_W'(1);
                else if (match_count != '1)
                    match_count <= match_count + CNT_W'(1);
            end else if (clr_count) begin
                match_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sd_pattern_detector.sv
// Bench for sd_pattern_detector: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the matching rules.
module tb_sd_pattern_detector;
    localparam int         MAX_LEN = 8;
    localparam int         CNT_W   = 4;
    localparam int         LEN_W   = 4;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [7:0] DEF_PAT = 8'b0000_0110;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             din = 1'b0, din_valid = 1'b0, cfg_we = 1'b0;
    logic [7:0]       cfg_pattern = DEF_PAT;
    logic [LEN_W-1:0] cfg_len = 4'd4;
    logic             cfg_overlap = 1'b1, clr_count = 1'b0;
    logic             dout;
    logic [3:0]       led;
    logic [CNT_W-1:0] match_count;

    sd_pattern_detector #(
        .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .DEF_PATTERN(DEF_PAT),
        .DEF_LEN(4), .DEF_OVERLAP(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .dout(dout), .led(led), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int pulses = 0, run = 0, maxrun = 0, last_led = 0;

    function automatic void chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Model: the accepted bits since the last clear point live in a queue; a match
    // is "enough fresh bits and the newest len bits equal the pattern".
    bit [7:0] m_pat;
    int       m_len, avail, e_cnt;
    bit       m_ovl, e_dout;
    bit [3:0] e_led;
    bit       q[$];

    always @(posedge clk or negedge reset_n) begin
        bit hit;
        if (!reset_n) begin
            m_pat = DEF_PAT; m_len = 4; m_ovl = 1'b1;
            q.delete(); avail = 0;
            e_dout = 1'b0; e_led = 4'd0; e_cnt = 0;
        end else begin
            hit = 1'b0;
            if (cfg_we) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_ovl = cfg_overlap;
                q.delete(); avail = 0;
            end else if (din_valid) begin
                q.push_back(din);
                if (q.size() > 40) void'(q.pop_front());
                if (avail < 64) avail++;
                if (m_len > 0 && avail >= m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (q[q.size()-1-i] != m_pat[i]) hit = 1'b0;
                end
                if (hit && !m_ovl) avail = 0;
            end
            e_dout = hit;
            e_led  = hit ? m_pat[3:0] : 4'd0;
            if (hit) e_cnt = clr_count ? 1 : ((e_cnt == CNT_MAX) ? CNT_MAX : e_cnt + 1);
            else if (clr_count) e_cnt = 0;
        end
    end

    always @(negedge clk) begin
        chk("dout", dout, e_dout);
        chk("led", led, e_led);
        chk("match_count", match_count, e_cnt);
        if (dout) begin
            pulses++;
            last_led = led;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b);
        din = b; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic sendv(input bit [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic load(input bit [7:0] p, input int l, input bit o);
        cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        cfg_pattern = DEF_PAT; cfg_len = 4'd4; cfg_overlap = 1'b1;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        tick(); tick();
        chk("reset_dout", dout, 0);
        chk("reset_led", led, 0);
        chk("reset_count", match_count, 0);
        reset_n = 1'b1;
        tick();

        // Defaults, overlapping: 0110110 matches twice.
        pulses = 0;
        sendv(8'b0011_0110, 7); idle(1);
        chk("t1_pulses", pulses, 2);
        chk("t1_count", match_count, 2);
        chk("t1_led", last_led, 4'b0110);

        // Non-overlapping on the same stream matches once.
        clr_count = 1'b1; tick(); clr_count = 1'b0;
        load(8'h06, 4, 1'b0);
        pulses = 0;
        sendv(8'b0011_0110, 7); idle(1);
        chk("t2_pulses", pulses, 1);
        chk("t2_count", match_count, 1);

        // Eight-bit pattern with valid gaps between bits.
        load(8'b1011_0101, 8, 1'b1);
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            send(8'hB5 >> i);
            idle(3);
        end
        chk("t3_pulses", pulses, 1);
        chk("t3_led", last_led, 4'b0101);
        chk("t3_count", match_count, 2);

        // Single-bit pattern: continuous pulses and counter saturation.
        load(8'h01, 1, 1'b1);
        pulses = 0; maxrun = 0;
        repeat (20) send(1'b1);
        idle(1);
        chk("t4_pulses", pulses, 20);
        chk("t4_run", maxrun, 20);
        chk("t4_sat", match_count, CNT_MAX);
        clr_count = 1'b1; send(1'b1); clr_count = 1'b0; idle(1);
        chk("t4_clr_hit", match_count, 1);

        // Length 0 disables; oversize length clamps to MAX_LEN.
        load(8'h00, 0, 1'b1);
        pulses = 0;
        repeat (40) send(1'($urandom_range(0, 1)));
        idle(1);
        chk("t5_len0", pulses, 0);
        load(8'hA5, MAX_LEN + 3, 1'b1);
        pulses = 0;
        sendv(8'hA5, 8); idle(1);
        chk("t5_clamp", pulses, 1);

        // cfg_we mid-pattern drops din; reset mid-pattern restores defaults.
        load(8'h09, 4, 1'b0);
        pulses = 0;
        send(1'b1); send(1'b0);
        din = 1'b0; din_valid = 1'b1; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0; din_valid = 1'b0;
        send(1'b1); send(1'b0); send(1'b0);
        pulse_reset();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        idle(1);
        chk("t6_pulses", pulses, 1);
        chk("t6_led", last_led, 4'b0110);

        // Randomized traffic, checked each cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            cfg_we = ($urandom_range(0, 99) < 2);
            if (cfg_we) begin
                cfg_pattern = 8'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom_range(0, 1));
            end
            din       = 1'($urandom_range(0, 1));
            din_valid = ($urandom_range(0, 9) < 7);
            clr_count = ($urandom_range(0, 29) == 0);
            tick();
        end
        cfg_we = 1'b0; din_valid = 1'b0; clr_count = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_pattern_detector.md
# sd_pattern_detector

Programmable serial sequence detector, the parametrised successor to the team's fixed 4-bit Mealy detectors. It matches a runtime-loaded pattern of 1..MAX_LEN bits on a qualified serial input. Overlapping or non-overlapping detection is selectable, and the block keeps a saturating match counter. It sits between the board's input synchroniser and the LED/status logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_0110: pattern loaded at reset (MAX_LEN bits).
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVERLAP, 1: overlap mode loaded at reset.
- LEN_W is derived as $clog2(MAX_LEN)+1. It is not a user parameter.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- cfg_we  in  1  one-cycle strobe that loads the cfg_* inputs.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- dout  out  1  one-cycle match pulse (registered).
- led  out  4  cfg_pattern[3:0] (zero-extended) during a dout pulse, else 0.
- match_count  out  CNT_W  saturating count of matches.

## Operation
Internal state:
- hist[MAX_LEN-1:0]: history shift register.
- fill: count of valid bits accepted since the last clear, saturating at len.
- Active configuration: pat, len, ovl.

Effective length and enable:
- len of 0 disables detection. dout is never asserted, but hist still shifts.
- A cfg_len greater than MAX_LEN is clamped to MAX_LEN at load.
- len of 1 is legal: every accepted bit equal to pat[0] matches.

Match condition (combinational, evaluated when din_valid=1 and cfg_we=0):
- fill ≥ len-1, and
- {hist[len-2:0], din} == pat[len-1:0].

On each accepted bit:
- hist is updated to {hist[MAX_LEN-2:0], din}.
- On a match with ovl=1: fill is kept, so the bits of the match can start the next match.
- On a match with ovl=0: fill is cleared to 0, so the next match needs len fresh bits.
- Without a match: fill increments, saturating at len.

Configuration load (cfg_we=1):
- pat, len (after clamping) and ovl are loaded.
- hist and fill are cleared.
- dout and led go to 0 on the next edge.
- din is ignored that cycle, even if din_valid=1.
- match_count is kept.

Counter:
- match_count increments on the same edge that sets dout.
- It holds at 2^CNT_W-1 once there.
- clr_count with no match that cycle: match_count becomes 0.
- clr_count together with a match: match_count becomes 1.

## Timing
Reset values (reset_n=0, asynchronous):
- dout=0, led=0, match_count=0.
- hist=0, fill=0.
- pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP.

Latency:
- dout and led rise on the clk edge that samples the last bit of the pattern.
- They are high for exactly one cycle, then return to 0 unless the next accepted bit also matches.
- Back-to-back dout pulses are possible only with ovl=1 (a self-overlapping pattern) or len=1.

din_valid low:
- No shift and no fill change.
- dout=0 and led=0 on the next edge.
- Gaps in din_valid do not break a partial match.

Reset mid-pattern:
- Partial history is lost immediately.
- The pattern returns to the defaults, not to the last loaded configuration.

A cfg_we arriving during a dout pulse does not truncate the current pulse. dout drops on the following edge as for any non-match cycle.

## Test plan
- Reset defaults (pattern 0110, len 4, overlap), stream 0,1,1,0,1,1,0 with din_valid=1 -> dout pulses after bit 4 and bit 7; led=4'b0110 in those cycles; match_count=2.
- Same stream after loading cfg_overlap=0 -> single pulse after bit 4; match_count=1.
- Load pattern 8'b1011_0101, len 8; insert din_valid=0 gaps of 3 cycles between bits -> exactly one pulse on the last bit; led=4'b0101.
- Load pattern 1, len 1; run with CNT_W=4 (pulse after every 1 bit), apply twenty 1s -> dout high 20 consecutive cycles; match_count saturates at 15; assert clr_count together with a match -> count=1.
- Load cfg_len=0 -> dout is never asserted for arbitrary input. Load cfg_len=MAX_LEN+3 -> length is clamped, and a MAX_LEN-bit match is detected.
- Assert cfg_we together with din_valid in the middle of a pattern, then assert reset_n=0 in the middle of a second pattern -> no false pulses; after reset, the default 0110 is detected from fresh bits only.
